dram_ctrl: RTL and testbench

- Parametrised data-memory controller for the single-cycle and pipelined miniLA cores. Replaces the fixed 64 KB word-only DRAM wrapper.
- Owns a word-organised array and performs true byte-lane writes for byte, half and word stores, so there is no read-modify-write through the read port.
- Returns loads sign- or zero-extended after a programmable read latency, with a valid handshake.
- Flags misaligned or illegal accesses instead of silently corrupting memory.

---
 rtl/dram_ctrl.sv | 130 +++++++++++++
 tb/tb_dram_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// Data-memory controller: word-organised array with byte-lane stores,
// RD_LAT-deep load pipeline, sign/zero extension and alignment error flag.
module dram_ctrl #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAST  = RD_LAT - 1;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              bad;
    logic [3:0]        be;
    logic [31:0]       wrep;
    logic              unused_hi;

    // Load pipeline stages: valid, captured word, op, lane, bad flag
    logic [RD_LAT-1:0]       pv;
    logic [RD_LAT-1:0]       pbad;
    logic [RD_LAT-1:0][31:0] pword;
    logic [RD_LAT-1:0][2:0]  pop;
    logic [RD_LAT-1:0][1:0]  plane;
    logic                    serr;

    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ext;

    // Address split, alignment check, byte enables and lane-replicated store data
    always_comb begin
        idx       = addr[ADDR_W+1:2];
        lane      = addr[1:0];
        unused_hi = ^addr[31:ADDR_W+2];
        bad       = 1'b1;
        be        = '0;
        wrep      = wdata;
        case (mem_op)
            3'd0, 3'd4: begin
                bad  = 1'b0;
                be   = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
            end
            3'd1, 3'd5: begin
                bad  = lane[0];
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            3'd2: begin
                bad  = |lane;
                be   = '1;
                wrep = wdata;
            end
            default: begin
                bad  = 1'b1;
                be   = '0;
                wrep = wdata;
            end
        endcase
    end

    // Byte-lane store into the array on the accepting edge (array is not reset)
    always_ff @(posedge clk) begin
        if (req && we && !bad && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wrep[8*i +: 8];
                end
            end
        end
    end

    // Capture loads at accept and shift them through RD_LAT stages; store error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv    <= '0;
            pbad  <= '0;
            pword <= '0;
            pop   <= '0;
            plane <= '0;
            serr  <= 1'b0;
        end else begin
            pv[0]    <= req && !we;
            pword[0] <= mem[idx];
            pop[0]   <= mem_op;
            plane[0] <= lane;
            pbad[0]  <= bad;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i]    <= pv[i-1];
                pword[i] <= pword[i-1];
                pop[i]   <= pop[i-1];
                plane[i] <= plane[i-1];
                pbad[i]  <= pbad[i-1];
            end
            serr <= req && we && bad;
        end
    end

    // Lane extraction and sign/zero extension from the last pipeline stage
    always_comb begin
        word = pword[LAST];
        bsel = word[{plane[LAST], 3'b000} +: 8];
        hsel = plane[LAST][1] ? word[31:16] : word[15:0];
        case (pop[LAST])
            3'd0:    ext = {{24{bsel[7]}}, bsel};
            3'd4:    ext = {24'b0, bsel};
            3'd1:    ext = {{16{hsel[15]}}, hsel};
            3'd5:    ext = {16'b0, hsel};
            default: ext = word;
        endcase
        rvalid = pv[LAST];
        rdata  = (pv[LAST] && !pbad[LAST]) ? ext : '0;
        err    = serr | (pv[LAST] & pbad[LAST]);
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench: two controller instances (small array / RD_LAT=1 and
// larger array / RD_LAT=4) share one stimulus stream and are checked every
// cycle against a byte-array reference model with a due-cycle response table.
module tb_dram_ctrl;

    localparam int AW_A  = 4;
    localparam int LAT_A = 1;
    localparam int AW_B  = 5;
    localparam int LAT_B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid_a, err_a, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dram_ctrl #(.ADDR_W(AW_A), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a)
    );

    dram_ctrl #(.ADDR_W(AW_B), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b)
    );

    // Reference model state: byte memory per instance, response table by cycle slot
    logic [7:0]  mm [2][128];
    bit          sv [2][8];
    logic [31:0] sd [2][8];
    bit          se [2][8];
    int unsigned cyc = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit misaligned(logic [2:0] op, logic [31:0] a);
        if (op == 3'd0 || op == 3'd4) return 1'b0;
        if (op == 3'd1 || op == 3'd5) return (a % 2) != 0;
        if (op == 3'd2) return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] extract(logic [2:0] op, logic [31:0] w, logic [31:0] a);
        logic [31:0] v;
        if (op == 3'd0 || op == 3'd4) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (op == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (op == 3'd1 || op == 3'd5) begin
            v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (op == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Model update on each accepted access; reset drops all pending responses
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++)
                for (int s = 0; s < 8; s++) begin
                    sv[k][s] = 1'b0;
                    se[k][s] = 1'b0;
                    sd[k][s] = '0;
                end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                int unsigned lat, dep, base, first, nb, due;
                logic [31:0] w;
                bit b;
                lat = (k == 0) ? LAT_A : LAT_B;
                dep = (k == 0) ? (1 << AW_A) : (1 << AW_B);
                sv[k][(cyc - 1) % 8] = 1'b0;
                se[k][(cyc - 1) % 8] = 1'b0;
                sd[k][(cyc - 1) % 8] = '0;
                if (req) begin
                    b    = misaligned(mem_op, addr);
                    base = ((addr / 4) % dep) * 4;
                    if (we) begin
                        if (b) begin
                            se[k][cyc % 8] = 1'b1;
                        end else begin
                            nb    = (mem_op == 3'd2) ? 4 : ((mem_op == 3'd1 || mem_op == 3'd5) ? 2 : 1);
                            first = (nb == 4) ? 0 : ((nb == 2) ? (addr % 4) / 2 * 2 : addr % 4);
                            for (int j = 0; j < 4; j++)
                                if (j < nb) mm[k][base + first + j] = 8'(wdata >> (8 * j));
                        end
                    end else begin
                        w   = {mm[k][base+3], mm[k][base+2], mm[k][base+1], mm[k][base]};
                        due = cyc + lat - 1;
                        sv[k][due % 8] = 1'b1;
                        sd[k][due % 8] = b ? 32'd0 : extract(mem_op, w, addr);
                        se[k][due % 8] = b;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int unsigned s;
        s = cyc % 8;
        chk("rvalid_a", {31'b0, rvalid_a}, {31'b0, sv[0][s]});
        chk("rdata_a",  rdata_a, sv[0][s] ? sd[0][s] : 32'd0);
        chk("err_a",    {31'b0, err_a},    {31'b0, se[0][s]});
        chk("rvalid_b", {31'b0, rvalid_b}, {31'b0, sv[1][s]});
        chk("rdata_b",  rdata_b, sv[1][s] ? sd[1][s] : 32'd0);
        chk("err_b",    {31'b0, err_b},    {31'b0, se[1][s]});
    end

    task automatic acc(bit w, logic [2:0] op, logic [31:0] a, logic [31:0] d);
        req    = 1'b1;
        we     = w;
        mem_op = op;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; mem_op = 3'd0; addr = '0; wdata = '0;
        idle(3);
        chk("reset_rvalid_a", {31'b0, rvalid_a}, 32'd0);
        chk("reset_rdata_b", rdata_b, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) acc(1'b1, 3'd2, 32'(i * 4), $urandom);

        // word write/read
        acc(1'b1, 3'd2, 32'h10, 32'h1234_5678);
        acc(1'b0, 3'd2, 32'h10, 32'h0);
        chk("t1_rvalid", {31'b0, rvalid_a}, 32'd1);
        chk("t1_rdata", rdata_a, 32'h1234_5678);
        chk("t1_err", {31'b0, err_a}, 32'd0);
        idle(3);
        chk("t1_rvalid_b", {31'b0, rvalid_b}, 32'd1);
        chk("t1_rdata_b", rdata_b, 32'h1234_5678);
        idle(2);

        // lane writes
        acc(1'b1, 3'd2, 32'h20, 32'hFFFF_FFFF);
        acc(1'b1, 3'd0, 32'h21, 32'h80);
        acc(1'b1, 3'd1, 32'h22, 32'hA55A);
        acc(1'b0, 3'd2, 32'h20, 32'h0); chk("lane_w",  rdata_a, 32'hA55A_80FF);
        acc(1'b0, 3'd0, 32'h21, 32'h0); chk("lane_b",  rdata_a, 32'hFFFF_FF80);
        acc(1'b0, 3'd4, 32'h21, 32'h0); chk("lane_bu", rdata_a, 32'h0000_0080);
        acc(1'b0, 3'd5, 32'h22, 32'h0); chk("lane_hu", rdata_a, 32'h0000_A55A);
        acc(1'b0, 3'd1, 32'h20, 32'h0); chk("lane_h",  rdata_a, 32'hFFFF_80FF);
        idle(5);

        // pipelined loads on the RD_LAT=4 instance, followed by an overwriting store
        acc(1'b1, 3'd2, 32'h0, 32'h1111_1111);
        acc(1'b1, 3'd2, 32'h4, 32'h2222_2222);
        acc(1'b1, 3'd2, 32'h8, 32'h3333_3333);
        acc(1'b0, 3'd2, 32'h0, 32'h0);
        acc(1'b0, 3'd2, 32'h4, 32'h0);
        acc(1'b0, 3'd2, 32'h8, 32'h0);
        acc(1'b1, 3'd2, 32'h0, 32'h0);
        chk("pipe0", rdata_b, 32'h1111_1111);
        idle(1); chk("pipe1", rdata_b, 32'h2222_2222);
        idle(1); chk("pipe2", rdata_b, 32'h3333_3333);
        acc(1'b0, 3'd2, 32'h0, 32'h0); chk("pipe_new", rdata_a, 32'h0);
        idle(5);

        // misalignment and illegal op
        acc(1'b1, 3'd2, 32'h30, 32'hCAFE_F00D);
        acc(1'b1, 3'd1, 32'h31, 32'hBEEF); chk("mis_st_err", {31'b0, err_a}, 32'd1);
        acc(1'b0, 3'd2, 32'h30, 32'h0); chk("mis_st_mem", rdata_a, 32'hCAFE_F00D);
        acc(1'b0, 3'd2, 32'h32, 32'h0);
        chk("mis_ld_v", {31'b0, rvalid_a}, 32'd1);
        chk("mis_ld_d", rdata_a, 32'h0);
        chk("mis_ld_e", {31'b0, err_a}, 32'd1);
        acc(1'b0, 3'd3, 32'h30, 32'h0); chk("ill_ld_e", {31'b0, err_a}, 32'd1);
        acc(1'b1, 3'd7, 32'h30, 32'h0); chk("ill_st_e", {31'b0, err_a}, 32'd1);
        acc(1'b0, 3'd2, 32'h30, 32'h0); chk("ill_st_mem", rdata_a, 32'hCAFE_F00D);
        idle(5);

        // reset with loads in flight on the RD_LAT=4 instance
        acc(1'b1, 3'd2, 32'h44, 32'h5A5A_0001);
        acc(1'b0, 3'd2, 32'h44, 32'h0);
        acc(1'b0, 3'd2, 32'h44, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        acc(1'b0, 3'd2, 32'h44, 32'h0); chk("rst_keep", rdata_a, 32'h5A5A_0001);
        idle(5);

        // aliasing on the 16-word instance
        acc(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
        acc(1'b0, 3'd2, 32'h0, 32'h0); chk("alias", rdata_a, 32'hDEAD_BEEF);
        idle(5);

        // randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                acc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
